// File: rtl/io_input_pkg.sv
// ============================================================================
// io_input_pkg - shared constants for the input conditioning and port blocks. Rev 1.0
// ============================================================================
`default_nettype none

package io_input_pkg;

   localparam int IO_IN_WIDTH               = 32;
   localparam int DEBOUNCE_TICK_DIV_DEFAULT = 50000;
   localparam int DEBOUNCE_STABLE_DEFAULT   = 4;

   typedef logic [31:0] io_addr_t;

   // Register map of the input-port block; software reads clean levels at PORT0, events at PORT1.
   localparam io_addr_t IO_IN_PORT0_ADDR = 32'h80;
   localparam io_addr_t IO_IN_PORT1_ADDR = 32'h84;
   localparam io_addr_t IO_IN_PORT2_ADDR = 32'h88;
   localparam io_addr_t IO_IN_PORT3_ADDR = 32'h8c;

   function automatic int tick_cnt_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/io_debounce_bit.sv
// ============================================================================
// io_debounce_bit - one-bit synchroniser, sample-window debouncer and sticky rise flag. Rev 1.0
// ============================================================================
`default_nettype none

module io_debounce_bit
   import io_input_pkg::*;
#(
   parameter int STABLE_SAMPLES = DEBOUNCE_STABLE_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw_i,
   input  logic sample_tick_i,
   input  logic evt_clr_i,
   output logic clean_o,
   output logic rise_evt_o
);

   logic                      sync1_q;
   logic                      sync2_q;
   logic [STABLE_SAMPLES-1:0] sh_q;
   logic [STABLE_SAMPLES-1:0] sh_d;
   logic                      clean_q;
   logic                      clean_d;
   logic                      evt_q;
   logic                      evt_d;

   // A set in the same cycle as a clear overrides the clear, so no event is lost.
   always_comb begin
      sh_d    = sh_q;
      clean_d = clean_q;
      evt_d   = evt_q;
      if (evt_clr_i) begin
         evt_d = 1'b0;
      end
      if (sample_tick_i) begin
         sh_d = {sh_q[STABLE_SAMPLES-2:0], sync2_q};
         if ((&sh_d) && !clean_q) begin
            clean_d = 1'b1;
            evt_d   = 1'b1;
         end else if (~|sh_d) begin
            clean_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sh_q    <= '0;
         clean_q <= 1'b0;
         evt_q   <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         sh_q    <= sh_d;
         clean_q <= clean_d;
         evt_q   <= evt_d;
      end
   end

   assign clean_o    = clean_q;
   assign rise_evt_o = evt_q;

endmodule

`default_nettype wire

// File: rtl/io_input_debounce.sv
// ============================================================================
// io_input_debounce - conditions raw switch/button inputs into clean levels and rise events. Rev 1.0
// ============================================================================
`default_nettype none

module io_input_debounce
   import io_input_pkg::*;
#(
   parameter int WIDTH          = IO_IN_WIDTH,
   parameter int TICK_DIV       = DEBOUNCE_TICK_DIV_DEFAULT,
   parameter int STABLE_SAMPLES = DEBOUNCE_STABLE_DEFAULT
) (
   input  logic             io_clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] raw_in,
   input  logic             evt_clr,
   output logic [WIDTH-1:0] clean_out,
   output logic [WIDTH-1:0] rise_evt,
   output logic             sample_tick
);

   localparam int               CNT_W     = tick_cnt_width(TICK_DIV);
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             tick_q;
   logic             tick_d;

   // Tick is registered one cycle behind the terminal count, giving a TICK_DIV-cycle period.
   always_comb begin
      cnt_d  = cnt_q + CNT_W'(1);
      tick_d = 1'b0;
      if (cnt_q == TICK_LAST) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end
   end

   always_ff @(posedge io_clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign sample_tick = tick_q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      io_debounce_bit #(
         .STABLE_SAMPLES(STABLE_SAMPLES)
      ) u_bit (
         .clk_i        (io_clk),
         .rst_ni       (resetn),
         .raw_i        (raw_in[i]),
         .sample_tick_i(tick_q),
         .evt_clr_i    (evt_clr),
         .clean_o      (clean_out[i]),
         .rise_evt_o   (rise_evt[i])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_io_input_debounce.sv
// ============================================================================
// tb_io_input_debounce - directed self-checking bench, TICK_DIV=4 / STABLE_SAMPLES=3 / WIDTH=8. Rev 1.0
// ============================================================================
`default_nettype none

module tb_io_input_debounce;

   localparam int W = 8;
   localparam int T = 4;
   localparam int S = 3;

   logic         io_clk  = 1'b0;
   logic         resetn  = 1'b1;
   logic         evt_clr = 1'b0;
   logic [W-1:0] raw_in  = '0;
   logic [W-1:0] clean_out;
   logic [W-1:0] rise_evt;
   logic         sample_tick;
   logic [W-1:0] clean1;
   logic [W-1:0] evt1;
   logic         tick1;

   int errors = 0;
   int checks = 0;

   always #5 io_clk = ~io_clk;

   io_input_debounce #(.WIDTH(W), .TICK_DIV(T), .STABLE_SAMPLES(S)) dut (
      .io_clk     (io_clk),
      .resetn     (resetn),
      .raw_in     (raw_in),
      .evt_clr    (evt_clr),
      .clean_out  (clean_out),
      .rise_evt   (rise_evt),
      .sample_tick(sample_tick)
   );

   io_input_debounce #(.WIDTH(W), .TICK_DIV(1), .STABLE_SAMPLES(S)) dut1 (
      .io_clk     (io_clk),
      .resetn     (resetn),
      .raw_in     (raw_in),
      .evt_clr    (evt_clr),
      .clean_out  (clean1),
      .rise_evt   (evt1),
      .sample_tick(tick1)
   );

   task automatic test_reset();
      bit found;
      #2 resetn = 1'b0;
      raw_in = 8'hFF;
      #1;
      checks++;
      if (sample_tick !== 1'b0 || tick1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_tick_in_reset: got %b/%b expected 0/0", sample_tick, tick1);
      end
      repeat (3) @(negedge io_clk);
      resetn = 1'b1;
      @(negedge io_clk);
      checks++;
      if (clean_out !== 8'h00) begin
         errors++;
         $display("FAIL reset_clean: got %h expected 00", clean_out);
      end
      checks++;
      if (rise_evt !== 8'h00) begin
         errors++;
         $display("FAIL reset_evt: got %h expected 00", rise_evt);
      end
      checks++;
      if (sample_tick !== 1'b0) begin
         errors++;
         $display("FAIL reset_tick: got %b expected 0", sample_tick);
      end
      found = 1'b0;
      for (int c = 2; c <= 15; c++) begin
         @(negedge io_clk);
         if (clean_out === 8'hFF) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL reset_clean_rise: got %h expected FF within 15 cycles", clean_out);
      end
      checks++;
      if (rise_evt !== 8'hFF) begin
         errors++;
         $display("FAIL reset_evt_rise: got %h expected FF", rise_evt);
      end
   endtask

   task automatic test_glitch();
      bit found;
      int bad_clean;
      int bad_evt;
      raw_in = 8'h00;
      found  = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         @(negedge io_clk);
         if (clean_out === 8'h00) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL glitch_prep_fall: got %h expected 00 within 15 cycles", clean_out);
      end
      evt_clr = 1'b1;
      @(negedge io_clk);
      evt_clr = 1'b0;
      checks++;
      if (rise_evt !== 8'h00) begin
         errors++;
         $display("FAIL glitch_evt_clr: got %h expected 00", rise_evt);
      end
      bad_clean = 0;
      bad_evt   = 0;
      raw_in    = 8'h01;
      for (int c = 1; c <= 47; c++) begin
         @(negedge io_clk);
         if (c == 7) raw_in = 8'h00;
         if (clean_out[0] !== 1'b0) bad_clean++;
         if (rise_evt[0] !== 1'b0) bad_evt++;
      end
      checks++;
      if (bad_clean != 0) begin
         errors++;
         $display("FAIL glitch_clean: got %0d cycles with clean[0]=1 expected 0", bad_clean);
      end
      checks++;
      if (bad_evt != 0) begin
         errors++;
         $display("FAIL glitch_evt: got %0d cycles with rise_evt[0]=1 expected 0", bad_evt);
      end
   endtask

   task automatic test_press_release();
      bit found;
      int n;
      raw_in = 8'h04;
      found  = 1'b0;
      n      = 0;
      for (int c = 1; c <= 15; c++) begin
         @(negedge io_clk);
         n = c;
         if (clean_out === 8'h04) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL press_clean: got %h expected 04 within 15 cycles", clean_out);
      end
      checks++;
      if (rise_evt !== 8'h04) begin
         errors++;
         $display("FAIL press_evt: got %h expected 04", rise_evt);
      end
      repeat (20 - n) @(negedge io_clk);
      raw_in = 8'h00;
      found  = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         @(negedge io_clk);
         if (clean_out === 8'h00) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL release_clean: got %h expected 00 within 15 cycles", clean_out);
      end
      checks++;
      if (rise_evt !== 8'h04) begin
         errors++;
         $display("FAIL release_evt: got %h expected 04", rise_evt);
      end
   endtask

   task automatic test_clear_collision();
      bit found;
      bit done;
      int ticks;
      evt_clr = 1'b1;
      @(negedge io_clk);
      evt_clr = 1'b0;
      raw_in  = 8'h01;
      found   = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         @(negedge io_clk);
         if (clean_out === 8'h01) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found || rise_evt !== 8'h01) begin
         errors++;
         $display("FAIL collision_prep: got clean=%h evt=%h expected 01/01", clean_out, rise_evt);
      end
      // Bit1 goes clean on the third sample edge that can see its synchronised level.
      raw_in = 8'h03;
      ticks  = 0;
      done   = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge io_clk);
         if (c >= 2 && sample_tick === 1'b1) begin
            ticks++;
            if (ticks == 3) begin
               evt_clr = 1'b1;
               @(negedge io_clk);
               evt_clr = 1'b0;
               done = 1'b1;
               break;
            end
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL collision_ticks: got %0d ticks expected 3 within 20 cycles", ticks);
      end
      checks++;
      if (clean_out !== 8'h03) begin
         errors++;
         $display("FAIL collision_clean: got %h expected 03", clean_out);
      end
      checks++;
      if (rise_evt !== 8'h02) begin
         errors++;
         $display("FAIL collision_evt: got %h expected 02", rise_evt);
      end
   endtask

   task automatic test_mid_reset();
      bit found;
      int lat;
      raw_in = 8'h80;
      repeat (8) @(negedge io_clk);
      checks++;
      if (clean_out !== 8'h03 || rise_evt !== 8'h02) begin
         errors++;
         $display("FAIL midreset_pre: got clean=%h evt=%h expected 03/02", clean_out, rise_evt);
      end
      #2 resetn = 1'b0;
      #1;
      checks++;
      if (clean_out !== 8'h00 || rise_evt !== 8'h00) begin
         errors++;
         $display("FAIL midreset_async: got clean=%h evt=%h expected 00/00", clean_out, rise_evt);
      end
      checks++;
      if (sample_tick !== 1'b0 || tick1 !== 1'b0) begin
         errors++;
         $display("FAIL midreset_tick: got %b/%b expected 0/0", sample_tick, tick1);
      end
      @(negedge io_clk);
      resetn = 1'b1;
      found  = 1'b0;
      lat    = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge io_clk);
         lat = c;
         if (clean_out[7] === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found || lat < 11 || lat > 15) begin
         errors++;
         $display("FAIL midreset_latency: got %0d cycles (found=%0d) expected 11..15", lat, found);
      end
      checks++;
      if (clean_out !== 8'h80 || rise_evt !== 8'h80) begin
         errors++;
         $display("FAIL midreset_after: got clean=%h evt=%h expected 80/80", clean_out, rise_evt);
      end
   endtask

   task automatic test_tick_period();
      bit found;
      int bad;
      int bad1;
      found = 1'b0;
      for (int c = 1; c <= T; c++) begin
         @(negedge io_clk);
         if (sample_tick === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL tick_first: got no pulse expected one within %0d cycles", T);
      end
      bad  = 0;
      bad1 = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge io_clk);
         if (sample_tick !== ((k % T) == 0)) bad++;
         if (tick1 !== 1'b1) bad1++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL tick_period: got %0d wrong cycles expected 0", bad);
      end
      checks++;
      if (bad1 != 0) begin
         errors++;
         $display("FAIL tick_div1: got %0d cycles with tick=0 expected 0", bad1);
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_press_release();
      test_clear_collision();
      test_mid_reset();
      test_tick_period();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
